// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Identifies which requester owns (or last owned) the memory port.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    // A fetch always moves one 32-bit instruction word.
    localparam logic [7:0] FETCH_WLEN = 8'd4;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one registered memory port between the
// instruction-fetch and data load/store requesters. Each grant runs to
// completion over mem_req/mem_ack, guarded by an optional timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [7:0]        d_wlen,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wlen,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter just wide enough to reach TIMEOUT; one bit when disabled.
    localparam int TMO_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

    state_e              state_q,     state_d;
    gnt_e                last_q,      last_d;
    logic [TMO_W-1:0]    tmo_cnt_q,   tmo_cnt_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]          mem_wlen_q,  mem_wlen_d;
    logic                if_done_q,   if_done_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic                if_err_q,    if_err_d;
    logic                d_done_q,    d_done_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                d_err_q,     d_err_d;

    logic                grant_i;
    logic                tmo_hit;

    // Fetch wins when it is the only requester, or on a tie when data went last.
    assign grant_i = if_req && (!d_req || (last_q == GNT_D));
    assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

    // Next-state decode: grant in IDLE, wait for ack/timeout in BUSY, pulse done in RESP.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wlen_d  = mem_wlen_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        d_done_d    = 1'b0;
        d_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (grant_i) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_wlen_d  = FETCH_WLEN;
                    last_d      = GNT_I;
                    state_d     = BUSY_I;
                end else if (d_req) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wlen_d  = d_wlen;
                    last_d      = GNT_D;
                    state_d     = BUSY_D;
                end
            end

            BUSY_I, BUSY_D: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (mem_ack) begin
                    // An ack in the timeout cycle still completes cleanly.
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == BUSY_I) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = mem_we_q ? '0 : mem_rdata;
                    end
                end else if (tmo_hit) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == BUSY_I) begin
                        if_done_d  = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end
            end

            RESP: begin
                tmo_cnt_d = '0;
                state_d   = IDLE;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                tmo_cnt_d = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= GNT_D;
            tmo_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wlen_q  <= '0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wlen_q  <= mem_wlen_d;
            if_done_q   <= if_done_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wlen  = mem_wlen_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout so the expiry path is reachable.
module tb_mem_arbiter;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [7:0]        d_wlen;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wlen;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wlen   (d_wlen),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wlen (mem_wlen),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #12;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wlen    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // ---- reset values
        #22;
        chk("rst_mem_req",  mem_req,  0);
        chk("rst_mem_we",   mem_we,   0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wlen", mem_wlen, 0);
        chk("rst_if_done",  if_done,  0);
        chk("rst_d_done",   d_done,   0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata",  d_rdata,  0);
        chk("rst_errs",     {if_err, d_err}, 0);
        rst = 1'b1;
        #1;

        // ---- single fetch, upper word selected by addr[2]
        if_req  = 1'b1;
        if_addr = 64'h8000_0004;
        tick();
        chk("f1_mem_req",  mem_req,  1);
        chk("f1_mem_addr", mem_addr, 64'h8000_0004);
        chk("f1_mem_we",   mem_we,   0);
        chk("f1_mem_wlen", mem_wlen, 8'd4);
        chk("f1_no_done",  if_done,  0);
        mem_ack   = 1'b1;
        mem_rdata = 64'h1111_2222_3333_4444;
        tick();
        chk("f1_if_done",  if_done,  1);
        chk("f1_if_rdata", if_rdata, 32'h1111_2222);
        chk("f1_if_err",   if_err,   0);
        chk("f1_mem_req0", mem_req,  0);
        chk("f1_d_done",   d_done,   0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();
        chk("f1_done_pulse", if_done, 0);
        tick();

        // ---- simultaneous requests after reset: fetch first, then data
        do_reset();
        if_req  = 1'b1;
        if_addr = 64'h0000_0100;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h0000_2008;
        d_wlen  = 8'd8;
        tick();
        chk("sim_first_addr", mem_addr, 64'h0000_0100);
        chk("sim_first_we",   mem_we,   0);
        mem_ack   = 1'b1;
        mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        chk("sim_if_done",  if_done,  1);
        chk("sim_if_rdata", if_rdata, 32'hCCCC_DDDD);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();
        chk("sim_resp_req", mem_req, 0);
        tick();
        chk("sim_d_req",  mem_req,  1);
        chk("sim_d_addr", mem_addr, 64'h0000_2008);
        chk("sim_d_we",   mem_we,   0);
        chk("sim_d_wlen", mem_wlen, 8'd8);
        mem_ack   = 1'b1;
        mem_rdata = 64'h5555_6666_7777_8888;
        tick();
        chk("sim_d_done",  d_done,  1);
        chk("sim_d_rdata", d_rdata, 64'h5555_6666_7777_8888);
        chk("sim_d_err",   d_err,   0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();
        tick();

        // ---- store: operands stable while mem_req high, d_rdata forced 0
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h0000_3000;
        d_wdata = 64'hDEAD_BEEF_0000_0001;
        d_wlen  = 8'd8;
        tick();
        chk("st_mem_req",   mem_req,   1);
        chk("st_mem_we",    mem_we,    1);
        chk("st_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
        chk("st_mem_wlen",  mem_wlen,  8'd8);
        tick();
        chk("st_hold_req",   mem_req,   1);
        chk("st_hold_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
        chk("st_hold_addr",  mem_addr,  64'h0000_3000);
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("st_d_done",  d_done,  1);
        chk("st_d_rdata", d_rdata, 0);
        chk("st_d_err",   d_err,   0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        tick();
        tick();

        // ---- ack in the last allowed cycle beats the timeout
        d_req  = 1'b1;
        d_addr = 64'h0000_4008;
        tick();
        chk("ta_mem_req", mem_req, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ta_wait_req",  mem_req, 1);
            chk("ta_wait_done", d_done,  0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 64'h0000_0000_0000_1234;
        tick();
        chk("ta_d_done",  d_done,  1);
        chk("ta_d_err",   d_err,   0);
        chk("ta_d_rdata", d_rdata, 64'h1234);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();
        tick();

        // ---- no ack at all: timeout after 4 cycles of mem_req
        d_req  = 1'b1;
        d_addr = 64'h0000_4000;
        tick();
        chk("to_mem_req", mem_req, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_req",  mem_req, 1);
            chk("to_wait_done", d_done,  0);
        end
        tick();
        chk("to_mem_req0", mem_req, 0);
        chk("to_d_done",   d_done,  1);
        chk("to_d_err",    d_err,   1);
        chk("to_d_rdata",  d_rdata, 0);
        d_req = 1'b0;
        tick();
        chk("to_done_pulse", d_done, 0);
        chk("to_err_pulse",  d_err,  0);
        d_req  = 1'b1;
        d_addr = 64'h0000_4010;
        tick();
        chk("to_new_req",  mem_req,  1);
        chk("to_new_addr", mem_addr, 64'h0000_4010);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();
        tick();

        // ---- both held continuously: strict alternation starting with fetch
        if_req  = 1'b1;
        if_addr = 64'h0000_0500;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h0000_0600;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("rr_mem_req",  mem_req,  1);
            chk("rr_mem_addr", mem_addr, (n % 2 == 0) ? 64'h0000_0500 : 64'h0000_0600);
            mem_ack   = 1'b1;
            mem_rdata = 64'h0000_0000_0000_0077;
            tick();
            chk("rr_if_done", if_done, (n % 2 == 0) ? 1 : 0);
            chk("rr_d_done",  d_done,  (n % 2 == 0) ? 0 : 1);
            mem_ack = 1'b0;
            tick();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();

        // ---- reset during BUSY_D: mem_req drops at once, no done
        d_req  = 1'b1;
        d_addr = 64'h0000_7000;
        tick();
        chk("rb_mem_req", mem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rb_async_req", mem_req, 0);
        chk("rb_async_addr", mem_addr, 0);
        mem_ack = 1'b1;
        tick();
        chk("rb_no_done", d_done, 0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        rst     = 1'b1;
        tick();
        chk("rb_no_done2", d_done, 0);
        chk("rb_idle_req", mem_req, 0);
        if_req  = 1'b1;
        if_addr = 64'h0000_8000;
        d_req   = 1'b1;
        d_addr  = 64'h0000_9000;
        tick();
        chk("rb_fetch_wins", mem_addr, 64'h0000_8000);
        chk("rb_fetch_wlen", mem_wlen, 8'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
